// File: rtl/dir_motor_driver_pkg.sv
// Shared definitions for the steering-code consumer: steer codes (common with the
// direction controller), driver FSM states and duty width helper.
package dir_motor_driver_pkg;

  // Steer code {turn[1:0], severity[1:0]}
  localparam logic [3:0] STEER_PROCEED      = 4'b00_00;
  localparam logic [3:0] STEER_VEER_RIGHT   = 4'b10_01;
  localparam logic [3:0] STEER_HARD_RIGHT   = 4'b10_10;
  localparam logic [3:0] STEER_NINETY_RIGHT = 4'b10_11;
  localparam logic [3:0] STEER_VEER_LEFT    = 4'b01_01;
  localparam logic [3:0] STEER_HARD_LEFT    = 4'b01_10;
  localparam logic [3:0] STEER_NINETY_LEFT  = 4'b01_11;
  localparam logic [3:0] STEER_STOP         = 4'b11_11;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DEAD,
    ST_PIVOT
  } state_t;

  // Duty shares the PWM counter width so a full-scale duty is 2^PWM_BITS-1.
  function automatic int duty_width(input int pwm_bits);
    return pwm_bits;
  endfunction

endpackage

// File: rtl/dir_motor_driver_channel.sv
// One H-bridge channel: duty register slewed toward its target once per PWM
// period, plus the registered PWM compare.
module motor_channel
  import dir_motor_driver_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_STEP = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] target,
  input  logic                force_zero,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] cnt,
  output logic                pwm
);

  localparam int DW = duty_width(PWM_BITS);
  localparam logic [DW-1:0] STEP = DW'(RAMP_STEP);

  logic [DW-1:0] duty_reg, duty_next;
  logic          pwm_reg;

  always_comb begin
    duty_next = duty_reg;
    if (force_zero) begin
      duty_next = '0;
    end else if (wrap) begin
      // Clamp to the target so the last step never overshoots.
      if (target > duty_reg) begin
        duty_next = (target - duty_reg > STEP) ? duty_reg + STEP : target;
      end else if (target < duty_reg) begin
        duty_next = (duty_reg - target > STEP) ? duty_reg - STEP : target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_reg <= '0;
      pwm_reg  <= 1'b0;
    end else begin
      duty_reg <= duty_next;
      pwm_reg  <= !force_zero && (cnt < duty_reg);
    end
  end

  assign pwm = pwm_reg;

endmodule

// File: rtl/dir_motor_driver.sv
// Steer-code to dual H-bridge driver: decodes duty targets, owns the PWM counter
// and the RUN/DEAD/PIVOT sequencer that guards polarity reversals and pivots.
module dir_motor_driver
  import dir_motor_driver_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int BASE_DUTY   = 200,
  parameter int VEER_DUTY   = 120,
  parameter int PIVOT_DUTY  = 160,
  parameter int RAMP_STEP   = 8,
  parameter int DEAD_CYCLES = 50_000,
  parameter int PIVOT_HOLD  = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dir,
  input  logic       direction,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic       left_fwd,
  output logic       right_fwd,
  output logic       busy
);

  localparam int DW   = duty_width(PWM_BITS);
  localparam int TMAX = (DEAD_CYCLES > PIVOT_HOLD) ? DEAD_CYCLES : PIVOT_HOLD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [DW-1:0] BASE_D  = DW'(BASE_DUTY);
  localparam logic [DW-1:0] VEER_D  = DW'(VEER_DUTY);
  localparam logic [DW-1:0] PIVOT_D = DW'(PIVOT_DUTY);

  state_t                state_reg;
  logic [PWM_BITS-1:0]   cnt_reg;
  logic [TW-1:0]         timer_reg;
  logic                  left_fwd_reg, right_fwd_reg, busy_reg;

  logic [DW-1:0] tgt_l, tgt_r;
  logic [DW-1:0] ch_tgt [2];
  logic          rev_l, rev_r, halt, ninety;
  logic          req_l, req_r, mismatch, force_zero, wrap;
  logic [1:0]    pwm_bus;

  // STOP and every undefined code collapse to the same halt behaviour.
  always_comb begin
    tgt_l = '0;
    tgt_r = '0;
    rev_l = 1'b0;
    rev_r = 1'b0;
    halt  = 1'b0;
    case (dir)
      STEER_PROCEED:      begin tgt_l = BASE_D;  tgt_r = BASE_D;  end
      STEER_VEER_RIGHT:   begin tgt_l = BASE_D;  tgt_r = VEER_D;  end
      STEER_HARD_RIGHT:   begin tgt_l = BASE_D;  tgt_r = '0;      end
      STEER_VEER_LEFT:    begin tgt_l = VEER_D;  tgt_r = BASE_D;  end
      STEER_HARD_LEFT:    begin tgt_l = '0;      tgt_r = BASE_D;  end
      STEER_NINETY_RIGHT: begin tgt_l = PIVOT_D; tgt_r = PIVOT_D; rev_r = 1'b1; end
      STEER_NINETY_LEFT:  begin tgt_l = PIVOT_D; tgt_r = PIVOT_D; rev_l = 1'b1; end
      default:            halt = 1'b1;
    endcase
  end

  assign ninety   = (dir == STEER_NINETY_RIGHT) || (dir == STEER_NINETY_LEFT);
  assign req_l    = direction ^ rev_l;
  assign req_r    = direction ^ rev_r;
  assign mismatch = (req_l != left_fwd_reg) || (req_r != right_fwd_reg);
  assign wrap     = (cnt_reg == '1);

  // Pivot targets are fixed, so "latched on entry" reduces to ignoring dir in PIVOT.
  always_comb begin
    force_zero = 1'b0;
    ch_tgt[0]  = tgt_l;
    ch_tgt[1]  = tgt_r;
    case (state_reg)
      ST_RUN:  force_zero = mismatch | halt;
      ST_DEAD: force_zero = 1'b1;
      ST_PIVOT: begin
        if (halt) begin
          force_zero = 1'b1;
        end else begin
          ch_tgt[0] = PIVOT_D;
          ch_tgt[1] = PIVOT_D;
        end
      end
      default: force_zero = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      cnt_reg       <= '0;
      timer_reg     <= '0;
      left_fwd_reg  <= 1'b1;
      right_fwd_reg <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      cnt_reg  <= cnt_reg + 1'b1;
      busy_reg <= (state_reg != ST_RUN);
      case (state_reg)
        ST_RUN: begin
          if (mismatch) begin
            state_reg <= ST_DEAD;
            timer_reg <= '0;
          end else if (ninety) begin
            state_reg <= ST_PIVOT;
            timer_reg <= '0;
          end
        end
        ST_DEAD: begin
          // Polarity is sampled only at exit, absorbing toggles during the brake.
          if (timer_reg == TW'(DEAD_CYCLES - 1)) begin
            left_fwd_reg  <= req_l;
            right_fwd_reg <= req_r;
            timer_reg     <= '0;
            state_reg     <= ninety ? ST_PIVOT : ST_RUN;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        ST_PIVOT: begin
          if (halt || timer_reg == TW'(PIVOT_HOLD - 1)) begin
            state_reg <= ST_RUN;
            timer_reg <= '0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    motor_channel #(
      .PWM_BITS  (PWM_BITS),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .target     (ch_tgt[gi]),
      .force_zero (force_zero),
      .wrap       (wrap),
      .cnt        (cnt_reg),
      .pwm        (pwm_bus[gi])
    );
  end

  assign left_pwm  = pwm_bus[0];
  assign right_pwm = pwm_bus[1];
  assign left_fwd  = left_fwd_reg;
  assign right_fwd = right_fwd_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_dir_motor_driver.sv
// Bench for dir_motor_driver: directed scenarios then random steer/direction
// traffic, every cycle compared against a countdown/arithmetic model.
module tb_dir_motor_driver;

  localparam int PB = 4, BASE = 12, VEER = 6, PIV = 8, STEP = 4, DEAD = 8, HOLD = 64;
  localparam int PERIOD = 16;
  localparam int M_RUN = 0, M_DEAD = 1, M_PIVOT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dir;
  logic       direction;
  logic       left_pwm, right_pwm, left_fwd, right_fwd, busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state
  int m_cnt, m_mode, m_rem;
  int m_duty [2];
  bit m_pwm [2];
  bit m_fwd [2];
  bit m_busy;

  dir_motor_driver #(
    .PWM_BITS(PB), .BASE_DUTY(BASE), .VEER_DUTY(VEER), .PIVOT_DUTY(PIV),
    .RAMP_STEP(STEP), .DEAD_CYCLES(DEAD), .PIVOT_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .dir(dir), .direction(direction),
    .left_pwm(left_pwm), .right_pwm(right_pwm),
    .left_fwd(left_fwd), .right_fwd(right_fwd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic decode(input logic [3:0] code, output int tl, output int tr,
                        output bit rl, output bit rr, output bit halt, output bit nin);
    tl = 0; tr = 0; rl = 0; rr = 0; halt = 0; nin = 0;
    case (code)
      4'b0000: begin tl = BASE; tr = BASE; end
      4'b1001: begin tl = BASE; tr = VEER; end
      4'b1010: begin tl = BASE; tr = 0;    end
      4'b0101: begin tl = VEER; tr = BASE; end
      4'b0110: begin tl = 0;    tr = BASE; end
      4'b1011: begin tl = PIV;  tr = PIV; rr = 1; nin = 1; end
      4'b0111: begin tl = PIV;  tr = PIV; rl = 1; nin = 1; end
      default: halt = 1;
    endcase
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int tg [2];
    int d;
    bit rl, rr, halt, nin, ql, qr, zero;
    if (rst) begin
      m_cnt = 0; m_mode = M_RUN; m_rem = 0; m_busy = 0;
      for (int k = 0; k < 2; k++) begin
        m_duty[k] = 0; m_pwm[k] = 0; m_fwd[k] = 1;
      end
      return;
    end
    decode(dir, tg[0], tg[1], rl, rr, halt, nin);
    ql = direction ^ rl;
    qr = direction ^ rr;
    zero = 0;
    m_busy = (m_mode != M_RUN);
    case (m_mode)
      M_RUN: begin
        if (ql != m_fwd[0] || qr != m_fwd[1]) begin
          zero = 1; m_mode = M_DEAD; m_rem = DEAD;
        end else begin
          zero = halt;
          if (nin) begin m_mode = M_PIVOT; m_rem = HOLD; end
        end
      end
      M_DEAD: begin
        zero = 1;
        m_rem--;
        if (m_rem == 0) begin
          m_fwd[0] = ql; m_fwd[1] = qr;
          if (nin) begin m_mode = M_PIVOT; m_rem = HOLD; end
          else m_mode = M_RUN;
        end
      end
      default: begin
        if (halt) begin
          zero = 1; m_mode = M_RUN;
        end else begin
          tg[0] = PIV; tg[1] = PIV;
          m_rem--;
          if (m_rem == 0) m_mode = M_RUN;
        end
      end
    endcase
    for (int k = 0; k < 2; k++) begin
      m_pwm[k] = zero ? 1'b0 : (m_cnt < m_duty[k]);
      if (zero) m_duty[k] = 0;
      else if (m_cnt == PERIOD - 1) begin
        d = tg[k] - m_duty[k];
        if (d > STEP) d = STEP;
        if (d < -STEP) d = -STEP;
        m_duty[k] += d;
      end
    end
    m_cnt = (m_cnt + 1) % PERIOD;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("left_pwm", left_pwm, m_pwm[0]);
      chk("right_pwm", right_pwm, m_pwm[1]);
      chk("left_fwd", left_fwd, m_fwd[0]);
      chk("right_fwd", right_fwd, m_fwd[1]);
      chk("busy", busy, m_busy);
    end
  end

  task automatic count_high(input int n, output int lh, output int rh);
    lh = 0; rh = 0;
    for (int i = 0; i < n; i++) begin
      step();
      lh += int'(left_pwm);
      rh += int'(right_pwm);
    end
  endtask

  // Length of the next contiguous busy-high run, bounded.
  task automatic busy_run(output int len);
    int guard;
    guard = 0; len = 0;
    while (!busy && guard < 200) begin step(); guard++; end
    while (busy && len < 500) begin len++; step(); end
  endtask

  logic [3:0] codes [11] = '{4'b0000, 4'b1001, 4'b1010, 4'b1011, 4'b0101,
                             4'b0110, 4'b0111, 4'b1111, 4'b0011, 4'b1100, 4'b0100};

  initial begin
    int lh, rh, len, run, best;
    bit in_run;
    rst = 1; dir = 4'b0000; direction = 1;
    step();
    chk_en = 1;
    repeat (2) step();
    chk("reset left_pwm", left_pwm, 1'b0);
    chk("reset right_pwm", right_pwm, 1'b0);
    chk("reset left_fwd", left_fwd, 1'b1);
    chk("reset right_fwd", right_fwd, 1'b1);
    chk("reset busy", busy, 1'b0);

    // Ramp to steady PROCEED
    rst = 0; dir = 4'b0000;
    repeat (64) step();
    count_high(PERIOD, lh, rh);
    chk_int("proceed left highs", lh, 12);
    chk_int("proceed right highs", rh, 12);

    // Veer left: left settles at 6, right stays 12, no brake
    dir = 4'b0101;
    repeat (48) step();
    count_high(PERIOD, lh, rh);
    chk_int("veer left highs", lh, 6);
    chk_int("veer right highs", rh, 12);
    chk("veer busy", busy, 1'b0);

    // Reverse: 8-cycle brake then both polarities backwards
    dir = 4'b0000;
    repeat (32) step();
    direction = 0;
    busy_run(len);
    chk_int("reverse dead length", len, DEAD);
    chk("reverse left_fwd", left_fwd, 1'b0);
    chk("reverse right_fwd", right_fwd, 1'b0);
    direction = 1;
    busy_run(len);
    repeat (64) step();

    // Ninety right with PROCEED at pivot cycle 20
    dir = 4'b1011;
    run = 0; best = 0; in_run = 0; lh = 0; rh = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (i == 28) begin
        chk("pivot left_fwd", left_fwd, 1'b1);
        chk("pivot right_fwd", right_fwd, 1'b0);
        dir = 4'b0000;
      end
      if (i >= 50 && i < 66) begin
        lh += int'(left_pwm); rh += int'(right_pwm);
      end
      if (busy) begin in_run = 1; run++; end
      else if (in_run && best == 0) best = run;
    end
    chk_int("pivot busy run", best, DEAD + HOLD);
    chk_int("pivot left highs", lh, PIV);
    chk_int("pivot right highs", rh, PIV);
    repeat (64) step();

    // STOP during pivot
    dir = 4'b1011;
    repeat (50) step();
    dir = 4'b1111;
    step();
    chk("stop left_pwm", left_pwm, 1'b0);
    chk("stop right_pwm", right_pwm, 1'b0);
    dir = 4'b0000;
    busy_run(len);
    repeat (70) step();
    for (int i = 0; i < 20 && !left_pwm; i++) step();
    dir = 4'b0011;
    step();
    chk("undef left_pwm", left_pwm, 1'b0);
    chk("undef right_pwm", right_pwm, 1'b0);

    // Reset mid-DEAD
    dir = 4'b0000;
    direction = 0;
    repeat (4) step();
    rst = 1;
    step();
    chk("rst busy", busy, 1'b0);
    chk("rst left_fwd", left_fwd, 1'b1);
    chk("rst right_fwd", right_fwd, 1'b1);
    chk("rst left_pwm", left_pwm, 1'b0);
    rst = 0;

    // Random traffic
    for (int s = 0; s < 80; s++) begin
      dir = codes[$urandom_range(0, 10)];
      if ($urandom_range(0, 3) == 0) direction = ~direction;
      if ($urandom_range(0, 24) == 0) begin
        rst = 1; step(); rst = 0;
      end
      repeat ($urandom_range(1, 100)) step();
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
